// File: rtl/configurable_ring_counter.sv
// Parametrised Johnson / one-hot ring counter with load, direction and wrap pulse.
// Illegal-state detection and correction is enabled by RING_COUNTER_SELF_CORRECT_EN.
module configurable_ring_counter #(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] RING_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] LSB_ONLY = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] seed_val;
    logic [WIDTH-1:0] step_val;
    logic             feed_up;
    logic             feed_dn;
    logic             wrap_hit;
    logic             bad;

    assign seed_val = mode ? RING_SEED : '0;

    // Ring mode recirculates the shifted-out bit, Johnson inverts it.
    always_comb begin
        feed_up  = mode ? count[WIDTH-1] : ~count[WIDTH-1];
        feed_dn  = mode ? count[0] : ~count[0];
        step_val = dir ? {feed_dn, count[WIDTH-1:1]}
                       : {count[WIDTH-2:0], feed_up};
        if (mode)
            wrap_hit = (step_val == (dir ? MSB_ONLY : LSB_ONLY));
        else
            wrap_hit = (step_val == '0);
    end

`ifdef RING_COUNTER_SELF_CORRECT_EN
    logic [WIDTH-1:0] inv;
    logic             john_ok;
    logic             ring_ok;

    // 0..01..1 has no carry overlap with itself+1; 1..10..0 is its inverse.
    always_comb begin
        inv     = ~count;
        john_ok = ((count & (count + WIDTH'(1))) == '0) ||
                  ((inv & (inv + WIDTH'(1))) == '0);
        ring_ok = (count != '0) &&
                  ((count & (count - WIDTH'(1))) == '0);
        bad     = mode ? ~ring_ok : ~john_ok;
    end
`else
    assign bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= seed_val;
            wrap    <= 1'b0;
            illegal <= 1'b0;
        end else if (load) begin
            count   <= load_value;
            wrap    <= 1'b0;
            illegal <= 1'b0;
        end else if (bad) begin
            count   <= seed_val;
            wrap    <= 1'b0;
            illegal <= 1'b1;
        end else if (enable) begin
            count   <= step_val;
            wrap    <= wrap_hit;
            illegal <= 1'b0;
        end else begin
            wrap    <= 1'b0;
            illegal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_configurable_ring_counter.sv
// Directed bench for configurable_ring_counter (WIDTH=4, RING_SEED=0001).
// Expected values follow RING_COUNTER_SELF_CORRECT_EN when it is defined.
module tb_configurable_ring_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       mode;
    logic       dir;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] count;
    logic       wrap;
    logic       illegal;

    int nvec = 0;
    int nerr = 0;

    configurable_ring_counter #(.WIDTH(4), .RING_SEED(4'b0001)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode),
        .dir        (dir),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .wrap       (wrap),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [3:0] c,
                               input logic w, input logic il);
        check({tag, ".count"}, {4'b0, count}, {4'b0, c});
        check({tag, ".wrap"}, {7'b0, wrap}, {7'b0, w});
        check({tag, ".illegal"}, {7'b0, illegal}, {7'b0, il});
    endtask

    task automatic do_reset(input logic m);
        enable = 1'b0;
        load   = 1'b0;
        mode   = m;
        rst_n  = 1'b0;
        tick();
        rst_n  = 1'b1;
    endtask

    logic [3:0] jseq [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    logic [3:0] rseq [4] = '{4'h8, 4'h4, 4'h2, 4'h1};

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        mode       = 1'b0;
        dir        = 1'b0;
        load       = 1'b0;
        load_value = 4'h0;
        #2;
        check_state("rst_async", 4'h0, 1'b0, 1'b0);
        tick();
        check_state("rst_johnson", 4'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Johnson up, full period
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_state($sformatf("john_up%0d", i), jseq[i], i == 7, 1'b0);
        end
        tick();
        check_state("john_up_next", 4'h1, 1'b0, 1'b0);

        // Ring down from seed
        dir = 1'b1;
        do_reset(1'b1);
        check_state("rst_ring", 4'h1, 1'b0, 1'b0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_state($sformatf("ring_dn%0d", i), rseq[i], i == 0, 1'b0);
        end
        tick();
        check_state("ring_dn_wrap2", 4'h8, 1'b1, 1'b0);
        enable = 1'b0;
        tick();
        check_state("ring_hold0", 4'h8, 1'b0, 1'b0);
        tick();
        check_state("ring_hold1", 4'h8, 1'b0, 1'b0);

        // Load beats enable, then reverse direction
        mode       = 1'b0;
        dir        = 1'b0;
        enable     = 1'b1;
        load       = 1'b1;
        load_value = 4'h7;
        tick();
        check_state("load", 4'h7, 1'b0, 1'b0);
        load = 1'b0;
        tick();
        check_state("load_up", 4'hF, 1'b0, 1'b0);
        dir = 1'b1;
        tick();
        check_state("rev0", 4'h7, 1'b0, 1'b0);
        tick();
        check_state("rev1", 4'h3, 1'b0, 1'b0);

        // Mode switch while count=0011
        mode = 1'b1;
        dir  = 1'b0;
        tick();
`ifdef RING_COUNTER_SELF_CORRECT_EN
        check_state("mode_sw", 4'h1, 1'b0, 1'b1);
        tick();
        check_state("mode_sw_next", 4'h2, 1'b0, 1'b0);
`else
        check_state("mode_sw", 4'h6, 1'b0, 1'b0);
        tick();
        check_state("mode_sw_next", 4'hC, 1'b0, 1'b0);
`endif

        // Illegal Johnson load
        mode       = 1'b0;
        load       = 1'b1;
        load_value = 4'h5;
        tick();
        check_state("ill_load", 4'h5, 1'b0, 1'b0);
        load = 1'b0;
        tick();
`ifdef RING_COUNTER_SELF_CORRECT_EN
        check_state("ill_fix", 4'h0, 1'b0, 1'b1);
        tick();
        check_state("ill_after", 4'h1, 1'b0, 1'b0);
`else
        check_state("ill_free0", 4'hB, 1'b0, 1'b0);
        tick();
        check_state("ill_free1", 4'h6, 1'b0, 1'b0);
        tick();
        check_state("ill_free2", 4'hD, 1'b0, 1'b0);
        tick();
        check_state("ill_free3", 4'hA, 1'b0, 1'b0);
`endif

        // Async reset between edges mid-count
        dir = 1'b0;
        do_reset(1'b0);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check_state("pre_rst_wrap", 4'h0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("mid_rst_a", 4'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check_state("pre_rst_cnt", 4'h7, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("mid_rst_b", 4'h0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        tick();
        check_state("restart0", 4'h1, 1'b0, 1'b0);
        tick();
        check_state("restart1", 4'h3, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
